// File: rtl/i2c_target_model.sv
// rtl/i2c_target_model.sv - oversampled I2C target with byte register file, auto-increment and clock stretching
module i2c_target_model #(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter int         REG_DEPTH   = 128,
  parameter int         STRETCH_CYC = 0,
  localparam int        PTR_W       = $clog2(REG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  output logic             scl_oe,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             init_we,
  input  logic [PTR_W-1:0] init_addr,
  input  logic [7:0]       init_data,
  output logic             busy,
  output logic             xfer_done,
  output logic [PTR_W-1:0] reg_ptr
);

  localparam int SW = (STRETCH_CYC > 0) ? $clog2(STRETCH_CYC + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEV_ACK, PTR, PTR_ACK, WDATA, W_ACK, RDATA, R_ACK, WAIT_P
  } state_t;

  state_t           state, state_n;
  logic             scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  logic             scl_rise, scl_fall, start_ev, stop_ev, stretching;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n, byte_in, rd_byte;
  logic             rw, rw_n, nine, nine_n;
  logic             sda_oe_n, busy_n, xfer_done_n;
  logic [PTR_W-1:0] reg_ptr_n, ptr_inc;
  logic [SW-1:0]    stretch_cnt, stretch_n;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [7:0]       wr_data;
  logic [7:0]       regs [REG_DEPTH];

  // Bit-level events come from the synchronised sample and its one-clk-old copy.
  // START/STOP need scl high on both samples so an sda edge racing scl is ignored.
  assign stretching = (stretch_cnt != '0);
  assign scl_rise   = scl_s2 & ~scl_d & ~stretching;
  assign scl_fall   = ~scl_s2 & scl_d & ~stretching;
  assign start_ev   = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_ev    = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_in    = {shreg[6:0], sda_s2};
  assign rd_byte    = regs[reg_ptr];
  assign ptr_inc    = (reg_ptr == PTR_W'(REG_DEPTH - 1)) ? '0 : reg_ptr + PTR_W'(1);
  assign scl_oe     = stretching;

  // Next-state and next-output logic for the byte/ACK protocol.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    rw_n        = rw;
    nine_n      = nine;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    xfer_done_n = 1'b0;
    reg_ptr_n   = reg_ptr;
    stretch_n   = stretching ? stretch_cnt - SW'(1) : '0;
    wr_en       = 1'b0;
    wr_idx      = reg_ptr;
    wr_data     = byte_in;
    if (stop_ev) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_ev) begin
      state_n   = DEVADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (state == DEVADDR || state == PTR || state == WDATA) begin
      if (scl_rise) begin
        shreg_n   = byte_in;
        bit_cnt_n = bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) begin
          bit_cnt_n = '0;
          nine_n    = 1'b0;
          if (state == DEVADDR) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_n = DEV_ACK;
              rw_n    = byte_in[0];
              busy_n  = 1'b1;
            end else begin
              state_n = WAIT_P;
              busy_n  = 1'b0;
            end
          end else if (state == PTR) begin
            if (int'(byte_in) < REG_DEPTH) begin
              reg_ptr_n = PTR_W'(byte_in);
              state_n   = PTR_ACK;
            end else begin
              state_n = WAIT_P;
            end
          end else begin
            wr_en       = 1'b1;
            reg_ptr_n   = ptr_inc;
            xfer_done_n = 1'b1;
            state_n     = W_ACK;
          end
        end
      end
    end else if (state == DEV_ACK || state == PTR_ACK || state == W_ACK) begin
      // First fall starts our ACK bit, the fall after the 9th rise ends it.
      if (scl_rise) begin
        nine_n = 1'b1;
      end else if (scl_fall) begin
        if (!nine) begin
          sda_oe_n = 1'b1;
        end else begin
          stretch_n = SW'(STRETCH_CYC);
          bit_cnt_n = '0;
          if (state == DEV_ACK && rw) begin
            state_n  = RDATA;
            shreg_n  = rd_byte;
            sda_oe_n = ~rd_byte[7];
          end else begin
            state_n  = (state == DEV_ACK) ? PTR : WDATA;
            sda_oe_n = 1'b0;
          end
        end
      end
    end else if (state == RDATA) begin
      if (scl_rise) begin
        shreg_n   = {shreg[6:0], 1'b0};
        bit_cnt_n = bit_cnt + 4'd1;
      end else if (scl_fall) begin
        if (bit_cnt == 4'd8) begin
          sda_oe_n = 1'b0;
          nine_n   = 1'b0;
          state_n  = R_ACK;
        end else begin
          sda_oe_n = ~shreg[7];
        end
      end
    end else if (state == R_ACK) begin
      if (scl_rise) begin
        xfer_done_n = 1'b1;
        reg_ptr_n   = ptr_inc;
        if (sda_s2) state_n = WAIT_P;
        else        nine_n  = 1'b1;
      end else if (scl_fall && nine) begin
        stretch_n = SW'(STRETCH_CYC);
        bit_cnt_n = '0;
        state_n   = RDATA;
        shreg_n   = rd_byte;
        sda_oe_n  = ~rd_byte[7];
      end
    end
  end

  // Synchroniser, edge-detect flops and protocol state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1      <= 1'b1;
      scl_s2      <= 1'b1;
      scl_d       <= 1'b1;
      sda_s1      <= 1'b1;
      sda_s2      <= 1'b1;
      sda_d       <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      rw          <= 1'b0;
      nine        <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      xfer_done   <= 1'b0;
      reg_ptr     <= '0;
      stretch_cnt <= '0;
    end else begin
      scl_s1      <= scl_i;
      scl_s2      <= scl_s1;
      scl_d       <= scl_s2;
      sda_s1      <= sda_i;
      sda_s2      <= sda_s1;
      sda_d       <= sda_s2;
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      rw          <= rw_n;
      nine        <= nine_n;
      sda_oe      <= sda_oe_n;
      busy        <= busy_n;
      xfer_done   <= xfer_done_n;
      reg_ptr     <= reg_ptr_n;
      stretch_cnt <= stretch_n;
    end
  end

  // Register file: the bus write is applied last so it wins on an index collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      if (init_we) regs[init_addr] <= init_data;
      if (wr_en)   regs[wr_idx]    <= wr_data;
    end
  end

endmodule

// File: tb/tb_i2c_target_model.sv
// tb/tb_i2c_target_model.sv - directed bus-master bench for i2c_target_model
module tb_i2c_target_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, m_scl, m_sda, scl_bus, sda_bus;
  logic       a_scl_oe, a_sda_oe, a_init_we, a_busy, a_xfer_done;
  logic [6:0] a_init_addr, a_reg_ptr;
  logic [7:0] a_init_data;
  logic       b_scl_oe, b_sda_oe, b_init_we, b_busy, b_xfer_done;
  logic [5:0] b_init_addr, b_reg_ptr;
  logic [7:0] b_init_data;

  assign scl_bus = m_scl & ~a_scl_oe & ~b_scl_oe;
  assign sda_bus = m_sda & ~a_sda_oe & ~b_sda_oe;

  i2c_target_model dut_a (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_bus), .scl_oe(a_scl_oe),
    .sda_i(sda_bus), .sda_oe(a_sda_oe), .init_we(a_init_we),
    .init_addr(a_init_addr), .init_data(a_init_data), .busy(a_busy),
    .xfer_done(a_xfer_done), .reg_ptr(a_reg_ptr)
  );

  i2c_target_model #(.DEV_ADDR(7'h50), .REG_DEPTH(64), .STRETCH_CYC(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_bus), .scl_oe(b_scl_oe),
    .sda_i(sda_bus), .sda_oe(b_sda_oe), .init_we(b_init_we),
    .init_addr(b_init_addr), .init_data(b_init_data), .busy(b_busy),
    .xfer_done(b_xfer_done), .reg_ptr(b_reg_ptr)
  );

  typedef enum {OP_START, OP_SR, OP_STOP, OP_WR, OP_RD} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic       ack;
  } vec_t;

  vec_t tbl [64];
  int   n_vec = 0;
  int   tests = 0;
  int   fails = 0;
  int   xd_a = 0, xd_b = 0, busy_a = 0, busy_b = 0;
  int   st_run = 0, st_runs = 0, st_bad = 0, st_last = 0;

  // Pulse/busy counters and stretch run-length tracker.
  always @(negedge clk) begin
    if (a_xfer_done) xd_a++;
    if (b_xfer_done) xd_b++;
    if (a_busy) busy_a++;
    if (b_busy) busy_b++;
    if (b_scl_oe) st_run++;
    else if (st_run != 0) begin
      st_runs++;
      st_last = st_run;
      if (st_run != 20) st_bad++;
      st_run = 0;
    end
  end

  task automatic add(input op_e op, input logic [7:0] d, input logic a);
    tbl[n_vec] = '{op: op, data: d, ack: a};
    n_vec++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scl_release();
    int t;
    m_scl = 1'b1;
    t = 0;
    while (scl_bus !== 1'b1 && t < 200) begin
      tick(1);
      t++;
    end
    if (scl_bus !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL scl_release: scl still %b after %0d clk, required 1", scl_bus, t);
    end
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_sda = b;
    tick(4);
    scl_release();
    tick(4);
    r = sda_bus;
    tick(4);
    m_scl = 1'b0;
    tick(4);
  endtask

  task automatic do_start();
    m_sda = 1'b1; m_scl = 1'b1; tick(4);
    m_sda = 1'b0; tick(4);
    m_scl = 1'b0; tick(4);
  endtask

  task automatic do_sr();
    m_sda = 1'b1; tick(4);
    scl_release(); tick(4);
    m_sda = 1'b0; tick(4);
    m_scl = 1'b0; tick(4);
  endtask

  task automatic do_stop();
    m_sda = 1'b0; tick(4);
    scl_release(); tick(4);
    m_sda = 1'b1; tick(8);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic m_ack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, r);
      d = {d[6:0], r};
    end
    bit_xfer(~m_ack, r);
  endtask

  task automatic run_range(input int lo, input int hi);
    logic       ack;
    logic [7:0] d;
    for (int i = lo; i < hi; i++) begin
      case (tbl[i].op)
        OP_START: do_start();
        OP_SR:    do_sr();
        OP_STOP:  do_stop();
        OP_WR: begin
          wr_byte(tbl[i].data, ack);
          check($sformatf("vec%0d_ack_%02h", i, tbl[i].data), {31'b0, ack}, {31'b0, tbl[i].ack});
        end
        default: begin
          rd_byte(tbl[i].ack, d);
          check($sformatf("vec%0d_rd", i), {24'b0, d}, {24'b0, tbl[i].data});
        end
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int s0, s1, s2, s3, s4, s5, s6, s7, s8;
    int snap_xd, snap_busy, snap_busy_b, snap_runs, snap_bad;
    logic ack;

    s0 = n_vec;  // reset readback of reg 0x00
    add(OP_START, 8'h00, 1'b0); add(OP_WR, 8'hD0, 1'b1); add(OP_WR, 8'h00, 1'b1);
    add(OP_SR, 8'h00, 1'b0); add(OP_WR, 8'hD1, 1'b1); add(OP_RD, 8'h00, 1'b0);
    add(OP_STOP, 8'h00, 1'b0);
    s1 = n_vec;  // write burst
    add(OP_START, 8'h00, 1'b0); add(OP_WR, 8'hD0, 1'b1); add(OP_WR, 8'h3B, 1'b1);
    add(OP_WR, 8'hA5, 1'b1); add(OP_WR, 8'h5A, 1'b1); add(OP_STOP, 8'h00, 1'b0);
    s2 = n_vec;  // read back the burst
    add(OP_START, 8'h00, 1'b0); add(OP_WR, 8'hD0, 1'b1); add(OP_WR, 8'h3B, 1'b1);
    add(OP_SR, 8'h00, 1'b0); add(OP_WR, 8'hD1, 1'b1); add(OP_RD, 8'hA5, 1'b1);
    add(OP_RD, 8'h5A, 1'b0); add(OP_STOP, 8'h00, 1'b0);
    s3 = n_vec;  // combined read across pointer wrap
    add(OP_START, 8'h00, 1'b0); add(OP_WR, 8'hD0, 1'b1); add(OP_WR, 8'h7F, 1'b1);
    add(OP_SR, 8'h00, 1'b0); add(OP_WR, 8'hD1, 1'b1); add(OP_RD, 8'h11, 1'b1);
    add(OP_RD, 8'h22, 1'b0); add(OP_STOP, 8'h00, 1'b0);
    s4 = n_vec;  // address mismatch
    add(OP_START, 8'h00, 1'b0); add(OP_WR, 8'hD2, 1'b0); add(OP_WR, 8'h55, 1'b0);
    add(OP_STOP, 8'h00, 1'b0);
    s5 = n_vec;  // pointer out of range on the 64-entry target
    add(OP_START, 8'h00, 1'b0); add(OP_WR, 8'hA0, 1'b1); add(OP_WR, 8'h40, 1'b0);
    add(OP_WR, 8'h77, 1'b0); add(OP_STOP, 8'h00, 1'b0);
    s6 = n_vec;  // single-byte write with stretching
    add(OP_START, 8'h00, 1'b0); add(OP_WR, 8'hA0, 1'b1); add(OP_WR, 8'h05, 1'b1);
    add(OP_WR, 8'h3C, 1'b1); add(OP_STOP, 8'h00, 1'b0);
    s7 = n_vec;  // read it back
    add(OP_START, 8'h00, 1'b0); add(OP_WR, 8'hA0, 1'b1); add(OP_WR, 8'h05, 1'b1);
    add(OP_SR, 8'h00, 1'b0); add(OP_WR, 8'hA1, 1'b1); add(OP_RD, 8'h3C, 1'b0);
    add(OP_STOP, 8'h00, 1'b0);
    s8 = n_vec;

    m_scl = 1'b1; m_sda = 1'b1; rst_n = 1'b0;
    a_init_we = 1'b0; a_init_addr = '0; a_init_data = '0;
    b_init_we = 1'b0; b_init_addr = '0; b_init_data = '0;
    tick(5);
    check("rst_scl_oe", {31'b0, a_scl_oe}, 32'd0);
    check("rst_sda_oe", {31'b0, a_sda_oe}, 32'd0);
    check("rst_busy", {31'b0, a_busy}, 32'd0);
    check("rst_reg_ptr", {25'b0, a_reg_ptr}, 32'd0);
    check("rst_xfer_done", {31'b0, a_xfer_done}, 32'd0);
    check("rst_b_scl_oe", {31'b0, b_scl_oe}, 32'd0);
    rst_n = 1'b1;
    tick(4);

    run_range(s0, s1);

    snap_xd = xd_a; snap_busy = busy_a;
    run_range(s1, s2);
    check("burst_xfer_done", xd_a - snap_xd, 32'd2);
    check("burst_reg_ptr", {25'b0, a_reg_ptr}, 32'h3D);
    check("burst_busy_seen", {31'b0, busy_a != snap_busy}, 32'd1);
    check("burst_busy_after_stop", {31'b0, a_busy}, 32'd0);
    run_range(s2, s3);

    a_init_we = 1'b1; a_init_addr = 7'h7F; a_init_data = 8'h11; tick(1);
    a_init_addr = 7'h00; a_init_data = 8'h22; tick(1);
    a_init_we = 1'b0; tick(2);
    snap_xd = xd_a;
    run_range(s3, s4);
    check("cread_reg_ptr", {25'b0, a_reg_ptr}, 32'h01);
    check("cread_xfer_done", xd_a - snap_xd, 32'd2);

    snap_busy = busy_a; snap_busy_b = busy_b; snap_xd = xd_a;
    run_range(s4, s5);
    check("mismatch_busy_a", busy_a - snap_busy, 32'd0);
    check("mismatch_busy_b", busy_b - snap_busy_b, 32'd0);
    check("mismatch_reg_ptr", {25'b0, a_reg_ptr}, 32'h01);
    check("mismatch_xfer_done", xd_a - snap_xd, 32'd0);

    snap_xd = xd_b;
    run_range(s5, s6);
    check("ptr_oor_reg_ptr", {26'b0, b_reg_ptr}, 32'd0);
    check("ptr_oor_xfer_done", xd_b - snap_xd, 32'd0);
    check("ptr_oor_busy_after_stop", {31'b0, b_busy}, 32'd0);

    snap_xd = xd_b; snap_runs = st_runs; snap_bad = st_bad;
    run_range(s6, s7);
    check("stretch_runs", st_runs - snap_runs, 32'd3);
    check("stretch_bad_len", st_bad - snap_bad, 32'd0);
    check("stretch_len", st_last, 32'd20);
    check("stretch_reg_ptr", {26'b0, b_reg_ptr}, 32'h06);
    check("stretch_xfer_done", xd_b - snap_xd, 32'd1);
    check("a_never_stretches", {31'b0, a_scl_oe}, 32'd0);
    run_range(s7, s8);

    do_start();
    wr_byte(8'hA0, ack);
    check("midstretch_ack", {31'b0, ack}, 32'd1);
    check("midstretch_active", {31'b0, b_scl_oe}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midstretch_reset_scl_oe", {31'b0, b_scl_oe}, 32'd0);
    check("midstretch_reset_busy", {31'b0, b_busy}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    do_stop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_model.md
Name: i2c_target_model

Overview:
- Parametrised, clock-oversampled I2C target (slave) with an internal byte register file.
- Emulates the IMU/sensor on the flight-controller I2C bus.
- Open-drain outputs drive scl/sda through tri-state buffers in the simulation bench.
- Successor to the fixed single-bit sda driver: adds address match, pointer/auto-increment, read/write, clock stretching, backdoor preload.

Parameters:
- DEV_ADDR, 7'h68, 7-bit target address matched on the address byte.
- REG_DEPTH, 128, number of 8-bit registers (2..256). PTR_W = clog2(REG_DEPTH).
- STRETCH_CYC, 0, clk cycles scl is held low after each ACK/data-bit-0 falling edge (0 = no stretching).

Ports:
- clk  in  1  system clock (oversamples scl, min 8x scl rate)
- rst_n  in  1  synchronous active-low reset
- scl_i  in  1  bus scl level
- scl_oe  out  1  1 = pull scl low (stretch)
- sda_i  in  1  bus sda level
- sda_oe  out  1  1 = pull sda low
- init_we  in  1  backdoor register write strobe
- init_addr  in  PTR_W  backdoor write index
- init_data  in  8  backdoor write data
- busy  out  1  high from matched START to STOP/mismatch
- xfer_done  out  1  one-clk pulse when a byte is written or read and ACKed/NACKed
- reg_ptr  out  PTR_W  current register pointer (debug)

Behaviour:
- Reset, synchronous on rst_n=0 at clk edge: scl_oe=0, sda_oe=0, busy=0, xfer_done=0, reg_ptr=0, state=IDLE, all registers=8'h00. Reset mid-transfer releases the bus on the next clk edge.
- scl_i/sda_i pass a 2-flop synchroniser plus a 1-flop edge detector. Bus events act 3 clk after the input change.
- START = sda fall while scl high. STOP = sda rise while scl high.
  - START in any state -> DEVADDR (repeated start allowed). STOP in any state -> IDLE.
- Data bits sampled on scl rising edge, MSB first. sda_oe is updated only on scl falling edge (3 clk latency).
- States: IDLE, DEVADDR, DEV_ACK, PTR, PTR_ACK, WDATA, W_ACK, RDATA, R_ACK, WAIT_P.
- DEVADDR: shift 8 bits.
  - [7:1] != DEV_ADDR -> WAIT_P, no ACK, busy=0.
  - Match -> DEV_ACK: sda_oe=1 for the 9th bit, busy=1.
  - Then R/W=0 -> PTR, R/W=1 -> RDATA.
- PTR: byte >= REG_DEPTH -> NACK (sda_oe stays 0), go to WAIT_P. Else reg_ptr=byte, ACK, go to WDATA.
- WDATA: byte written to reg[reg_ptr] at the 8th rising edge. ACK, xfer_done pulse, reg_ptr increments (REG_DEPTH-1 wraps to 0), back to WDATA.
- RDATA: load reg[reg_ptr] at the falling edge after ACK / Sr address. Drive bit n with sda_oe = ~bit, then release for the 9th bit (R_ACK).
  - Master ACK (sda low at 9th rising edge): reg_ptr++ with wrap, xfer_done pulse, continue RDATA.
  - Master NACK: xfer_done pulse, reg_ptr++, go to WAIT_P.
- WAIT_P: all outputs released until START or STOP.
- Stretch: if STRETCH_CYC>0, scl_oe=1 for exactly STRETCH_CYC clk starting at the scl falling edge that ends each ACK bit. Bit-level state machine is frozen while stretching. scl_oe never asserted when STRETCH_CYC=0.
- Backdoor: init_we writes reg[init_addr] in 1 clk in any state. If a bus write hits the same cycle, the bus write wins for the same index; different indices both write.
- START/STOP glitch: an sda change with scl high is only an event if scl is high on both synchronised samples. Data changes while scl is low are ignored.
- busy drops in the cycle STOP is detected.

Test Plan:
- Reset: hold rst_n=0 5 clk while bus idle high -> scl_oe=0, sda_oe=0, busy=0, reg_ptr=0. Backdoor read via bus of reg 0x00 returns 8'h00.
- Write burst: START, 0xD0, ptr 0x3B, data 0xA5 0x5A, STOP -> ACK on all 4 bytes, reg[0x3B]=0xA5, reg[0x3C]=0x5A, 2 xfer_done pulses, reg_ptr=0x3D.
- Combined read: preload reg[0x7F]=0x11 and reg[0x00]=0x22 via init_we. START 0xD0, ptr 0x7F, Sr 0xD1, read 2 bytes (ACK then NACK), STOP -> bytes 0x11, 0x22 (pointer wraps), reg_ptr=0x01.
- Address mismatch: START 0xD2 (0x69), STOP -> 9th bit sda stays high, busy never 1, no register change.
- Pointer out of range with REG_DEPTH=64: ptr byte 0x40 -> NACK, subsequent data bytes ignored until STOP.
- Stretch: STRETCH_CYC=20, write 1 byte -> scl_oe high exactly 20 clk after each ACK falling edge. Reset asserted mid-stretch -> scl_oe=0 next clk.
